// File: rtl/flappy_pkg.sv
// Shared constants and state encoding for the pipe obstacle sequencer.
package flappy_pkg;
   localparam int COORD_W = 12;
   localparam int DISP_W  = 640;
   localparam int DISP_H  = 480;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DEAD = 2'd2
   } pipe_state_t;
endpackage

// File: rtl/gap_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11), free-running; only reset holds it.
module gap_lfsr #(
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [15:0] o_state
);
   always_ff @(posedge i_clk) begin
      if (i_rst)
         o_state <= LFSR_SEED;
      else
         o_state <= {1'b0, o_state[15:1]} ^ (o_state[0] ? 16'hB400 : 16'h0000);
   end
endmodule

// File: rtl/pipe_scroller.sv
// Pipe pair scroll/respawn/score sequencer.
// Optional PIPE_SPEEDUP_EN: speed rises by one every 8 points, capped at 6.
//
// state | meaning
// IDLE  | pipe parked at spawn position, waiting for start
// RUN   | pipe scrolls on each animate strobe, scoring at the bird column
// DEAD  | positions and score frozen until start
module pipe_scroller
   import flappy_pkg::*;
#(
   parameter int          PIPE_HALF_W = 30,
   parameter int          GAP_HALF    = 60,
   parameter int          SPEED       = 2,
   parameter int          D_WIDTH     = DISP_W,
   parameter int          D_HEIGHT    = DISP_H,
   parameter int          BIRD_X      = 160,
   parameter int          GAP_MIN     = 100,
   parameter int          GAP_MAX     = 380,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_animate,
   input  logic               i_start,
   input  logic               i_halt,
   output logic [COORD_W-1:0] o_top_x1,
   output logic [COORD_W-1:0] o_top_x2,
   output logic [COORD_W-1:0] o_top_y1,
   output logic [COORD_W-1:0] o_top_y2,
   output logic [COORD_W-1:0] o_bot_x1,
   output logic [COORD_W-1:0] o_bot_x2,
   output logic [COORD_W-1:0] o_bot_y1,
   output logic [COORD_W-1:0] o_bot_y2,
   output logic [7:0]         o_score,
   output logic               o_score_pulse,
   output logic [1:0]         o_state
);
   localparam logic [COORD_W-1:0] X_RESET   = COORD_W'(D_WIDTH + PIPE_HALF_W);
   localparam logic [COORD_W-1:0] GAP_RESET = COORD_W'(D_HEIGHT / 2);
   localparam logic [COORD_W-1:0] HALF_W    = COORD_W'(PIPE_HALF_W);
   localparam logic [COORD_W-1:0] GAP_H     = COORD_W'(GAP_HALF);
   localparam logic [COORD_W-1:0] BIRD      = COORD_W'(BIRD_X);
   localparam logic [COORD_W-1:0] GMIN      = COORD_W'(GAP_MIN);
   localparam logic [8:0]         RANGE     = 9'(GAP_MAX - GAP_MIN + 1);

   pipe_state_t        state_q, state_d;
   logic [COORD_W-1:0] x_q, x_d, gap_q, gap_d, step, x_dec;
   logic [7:0]         score_q, score_d;
   logic               pulse_q, pulse_d;
   logic [15:0]        lfsr;
   logic [8:0]         rnd, off;
   logic [COORD_W-1:0] gap_new;
   logic               unused_lfsr;

   gap_lfsr #(.LFSR_SEED(LFSR_SEED)) u_lfsr (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .o_state (lfsr)
   );

   // RANGE >= 256 keeps a single conditional subtraction in range.
   assign rnd         = lfsr[8:0];
   assign off         = (rnd < RANGE) ? rnd : rnd - RANGE;
   assign gap_new     = GMIN + {3'd0, off};
   assign unused_lfsr = ^lfsr[15:9];

`ifdef PIPE_SPEEDUP_EN
   logic [3:0] speed_q, speed_d;
   assign step = {8'd0, speed_q};
`else
   assign step = COORD_W'(SPEED);
`endif
   assign x_dec = x_q - step;

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      gap_d   = gap_q;
      score_d = score_q;
      pulse_d = 1'b0;
`ifdef PIPE_SPEEDUP_EN
      speed_d = speed_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = RUN;
               score_d = 8'd0;
`ifdef PIPE_SPEEDUP_EN
               speed_d = 4'(SPEED);
`endif
            end
         end
         RUN: begin
            if (i_halt) begin
               state_d = DEAD;
            end else if (i_animate) begin
               if (x_q < HALF_W + step) begin
                  x_d   = X_RESET;
                  gap_d = gap_new;
               end else begin
                  x_d = x_dec;
                  if (x_q >= BIRD && x_dec < BIRD) begin
                     pulse_d = 1'b1;
                     if (score_q != 8'hFF)
                        score_d = score_q + 8'd1;
`ifdef PIPE_SPEEDUP_EN
                     if (score_d[2:0] == 3'd0 && speed_q < 4'd6)
                        speed_d = speed_q + 4'd1;
`endif
                  end
               end
            end
         end
         DEAD: begin
            if (i_start) begin
               state_d = IDLE;
               x_d     = X_RESET;
               gap_d   = GAP_RESET;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         x_q     <= X_RESET;
         gap_q   <= GAP_RESET;
         score_q <= 8'd0;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         gap_q   <= gap_d;
         score_q <= score_d;
         pulse_q <= pulse_d;
      end
   end

`ifdef PIPE_SPEEDUP_EN
   always_ff @(posedge i_clk) begin
      if (i_rst)
         speed_q <= 4'(SPEED);
      else
         speed_q <= speed_d;
   end
`endif

   assign o_top_x1      = x_q - HALF_W;
   assign o_top_x2      = x_q + HALF_W;
   assign o_top_y1      = '0;
   assign o_top_y2      = gap_q - GAP_H;
   assign o_bot_x1      = x_q - HALF_W;
   assign o_bot_x2      = x_q + HALF_W;
   assign o_bot_y1      = gap_q + GAP_H;
   assign o_bot_y2      = COORD_W'(D_HEIGHT - 1);
   assign o_score       = score_q;
   assign o_score_pulse = pulse_q;
   assign o_state       = state_q;
endmodule
